burst_buffer_fsm: RTL and testbench
===================================

# burst_buffer_fsm

Parametrised load/process/drain controller with a memory buffer.
- Captures a burst of `len` words through a valid/ready input port into an internal buffer of `DEPTH` entries.
- Optionally computes a full-precision sum over the stored words.
- Replays the words in order on a valid/ready output port, then pulses `done`.
- Sits between a producer that streams bursts and a consumer that needs buffered, rate-decoupled data plus a checksum.

## Interface
- `DATA_W`, default 8: data word width.
- `DEPTH`, default 8: buffer entries; power of two, ≥2.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width (derived, not overridden).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: begin a burst; sampled only in IDLE.
- `len` in ADDR_W+1: burst length for this burst; sampled with `start`.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block accepts an input word.
- `in_data` in DATA_W: input word.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the output word.
- `out_data` out DATA_W: output word; 0 whenever `out_valid`=0.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of burst.
- `sum_out` out DATA_W+ADDR_W: sum of the last burst's words.

## Operation
- States: IDLE, LOAD, PROCESS, DRAIN, DONE.
- Registered internals: `cnt_len` (ADDR_W+1), `wptr`, `rptr`, `acc` (DATA_W+ADDR_W).
- **IDLE**
  - `start`=1 and `len`≠0 → LOAD.
  - Latch `cnt_len` = min(`len`, `DEPTH`).
  - Clear `wptr`, `rptr` and `acc`, and clear `sum_out` to 0.
  - `start`=1 with `len`=0 is ignored; stay in IDLE.
- **LOAD**
  - `in_ready`=1.
  - On each `in_valid`&&`in_ready`: write `mem[wptr]` = `in_data`, then `wptr`++.
  - On the handshake that stores word `cnt_len`: `in_ready` drops the next cycle and the state moves to PROCESS (to DRAIN when the sum is compiled out).
  - `in_valid`=0 stalls indefinitely; no timeout.
- **PROCESS**
  - One word per cycle: `acc` += `mem[rptr]`, `rptr`++.
  - After `cnt_len` cycles: `sum_out` = final `acc`, `rptr` = 0, state → DRAIN.
- **DRAIN**
  - `out_valid`=1, `out_data` = `mem[rptr]`.
  - On each `out_valid`&&`out_ready`: `rptr`++.
  - After the `cnt_len`-th handshake → DONE.
  - `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- **DONE**: `done`=1 for exactly one cycle, then → IDLE.
- Arithmetic and storage rules:
  - `acc` is zero-extended addition. It never overflows, because DEPTH·(2^DATA_W−1) < 2^(DATA_W+ADDR_W).
  - `sum_out` holds its value through IDLE until the next accepted `start`.
  - Pointers wrap modulo DEPTH. When `cnt_len`=DEPTH, `wptr` returns to 0 after the final write.
  - Memory is not reset. Contents outside the `cnt_len` words written by the current burst are never output.
- `start` outside IDLE is ignored. `len` and `start` changes mid-burst have no effect.

## Timing
- Reset (`rst_n`=0 at a rising edge) gives, the following cycle:
  - state IDLE;
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `sum_out`=0;
  - pointers, `cnt_len` and `acc` = 0.
- Reset mid-burst aborts the burst immediately; partially loaded data is discarded.
- `start` accepted at edge k → LOAD from cycle k+1, and `busy`=1 from cycle k+1.
- With `in_valid`=1 and `out_ready`=1 throughout and N=`cnt_len`:
  - LOAD occupies N cycles, PROCESS N cycles, DRAIN N cycles.
  - `done` is high in cycle k+3N+1.
  - With the sum compiled out, `done` is high in cycle k+2N+1.
- Each valid/ready stall cycle extends the burst by one cycle.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `BURST_BUFFER_SUM_EN` defined:
  - PROCESS state present.
  - `sum_out` behaves as in Operation.
- `BURST_BUFFER_SUM_EN` undefined:
  - PROCESS state and `acc` removed; LOAD → DRAIN directly.
  - `sum_out` tied to 0.
  - All other behaviour is identical.

## Test plan
- **Basic burst** (DATA_W=8, DEPTH=8, SUM_EN): reset, then `start` with `len`=4 and inputs 0x01,0x02,0x03,0x04 streamed with no stalls → `out_data` sequence 01,02,03,04; `sum_out`=0x00A; `done` at start edge +13 cycles.
- **Full depth and wrap**: `len`=8 with all inputs 0xFF → `sum_out`=0x7F8 and 8 outputs of 0xFF. Then `len`=12 with inputs 1..8 → clamped to 8 words; `sum_out`=36.
- **Handshake stalls**: LFSR-random `in_valid` and `out_ready` with `len`=5 → data order preserved; `out_data` stable under stall; `in_ready` low outside LOAD.
- **Ignored starts**:
  - `start` with `len`=0 → `busy` stays 0.
  - `start` pulsed during DRAIN → no effect, and exactly one `done` pulse.
- **Reset mid-LOAD** after 2 of 6 words → next cycle all outputs at reset values. A fresh `len`=2 burst then outputs only the new words, with `sum_out` matching them.
- **SUM_EN undefined**: rerun the basic-burst scenario → `done` at start edge +9 cycles, `sum_out`=0.

Source files
------------

// File: rtl/burst_buffer_fsm.sv
// burst_buffer_fsm: load / process / drain controller around a small word buffer.
// A burst of up to DEPTH words is captured through a valid/ready input port,
// optionally summed, then replayed in order on a valid/ready output port,
// followed by a one-cycle done pulse.
// Build option: define BURST_BUFFER_SUM_EN to include the PROCESS state and the
// running sum; without it LOAD goes straight to DRAIN and sum_out reads 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start with a non-zero len
// LOAD    | accepting input words into mem until cnt_len are stored
// PROCESS | summing one stored word per cycle (sum build only)
// DRAIN   | presenting stored words on the output port in write order
// DONE    | one-cycle done pulse, then back to IDLE
module burst_buffer_fsm #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] sum_out
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
`ifdef BURST_BUFFER_SUM_EN
    ST_PROCESS = 3'd2,
`endif
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_len_q, cnt_len_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic                wr_last;
  logic                rd_last;
`ifdef BURST_BUFFER_SUM_EN
  logic [DATA_W+ADDR_W-1:0] acc_q, acc_d;
  logic [DATA_W+ADDR_W-1:0] sum_q, sum_d;
  logic [DATA_W+ADDR_W-1:0] acc_next;
`endif

  // Pointers count modulo DEPTH, so the last-word test compares a widened
  // pointer against cnt_len instead of relying on the pointer itself.
  assign rd_word = mem[rptr_q];
  assign wr_last = (({1'b0, wptr_q} + 1'b1) == cnt_len_q);
  assign rd_last = (({1'b0, rptr_q} + 1'b1) == cnt_len_q);
`ifdef BURST_BUFFER_SUM_EN
  assign acc_next = acc_q + (DATA_W+ADDR_W)'(rd_word);
`endif

  // Outputs decode from registered state only, so no ready/valid loops exist.
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? rd_word : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
`ifdef BURST_BUFFER_SUM_EN
  assign sum_out   = sum_q;
`else
  assign sum_out   = '0;
`endif

  // Buffer storage: written on input handshakes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && in_ready && in_valid) begin
      mem[wptr_q] <= in_data;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_len_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
`ifdef BURST_BUFFER_SUM_EN
      acc_q     <= '0;
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_len_q <= cnt_len_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
`ifdef BURST_BUFFER_SUM_EN
      acc_q     <= acc_d;
      sum_q     <= sum_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    cnt_len_d = cnt_len_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
`ifdef BURST_BUFFER_SUM_EN
    acc_d     = acc_q;
    sum_d     = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d   = ST_LOAD;
          cnt_len_d = (len > DEPTH_L) ? DEPTH_L : len;
          wptr_d    = '0;
          rptr_d    = '0;
`ifdef BURST_BUFFER_SUM_EN
          acc_d     = '0;
          sum_d     = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          wptr_d = wptr_q + 1'b1;
          if (wr_last) begin
`ifdef BURST_BUFFER_SUM_EN
            state_d = ST_PROCESS;
`else
            state_d = ST_DRAIN;
`endif
          end
        end
      end
`ifdef BURST_BUFFER_SUM_EN
      ST_PROCESS: begin
        acc_d  = acc_next;
        rptr_d = rptr_q + 1'b1;
        if (rd_last) begin
          sum_d   = acc_next;
          rptr_d  = '0;
          state_d = ST_DRAIN;
        end
      end
`endif
      ST_DRAIN: begin
        if (out_ready) begin
          rptr_d = rptr_q + 1'b1;
          if (rd_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_burst_buffer_fsm.sv
// tb_burst_buffer_fsm: directed bench for burst_buffer_fsm (DATA_W=8, DEPTH=8).
// Expected sum and done latency follow the BURST_BUFFER_SUM_EN build option.
module tb_burst_buffer_fsm;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
`ifdef BURST_BUFFER_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [ADDR_W:0]          len;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     busy;
  logic                     done;
  logic [DATA_W+ADDR_W-1:0] sum_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] src [16];
  logic [7:0] got [$];
  logic [7:0] lfsr = 8'hA5;

  burst_buffer_fsm #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .sum_out(sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum_out, 0);
  endtask

  // Runs one burst from src[], collecting outputs and checking handshake rules.
  task automatic burst(input int blen, input int nexp, input int exp_sum,
                       input bit stall, input bit pulse_drain);
    int start_cyc, budget, n_in, lat, done_cnt, exp_lat;
    bit hold_v, pulsed;
    logic [7:0] hold_d;
    got.delete();
    n_in = 0; lat = -1; done_cnt = 0; hold_v = 0; pulsed = 0; hold_d = '0;
    @(negedge clk);
    start = 1'b1; len = (ADDR_W+1)'(blen); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    budget = 0;
    while (budget < 400) begin
      if (hold_v) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_d);
      end
      chk("rdy_outside_load", in_ready & (out_valid | done), 0);
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = cyc - start_cyc - 1;
      end
      if (lat >= 0 && !done) break;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      in_valid  = stall ? lfsr[0] : 1'b1;
      out_ready = stall ? lfsr[3] : 1'b1;
      in_data   = src[n_in & 15];
      if (pulse_drain && out_valid && !pulsed) begin
        start = 1'b1; len = 4'd3; pulsed = 1'b1;
      end
      if (in_ready && in_valid) n_in++;
      if (out_valid && out_ready) got.push_back(out_data);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      @(negedge clk);
      start = 1'b0;
      budget++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (budget >= 400) chk("timeout", 0, 1);
    chk("out_count", got.size(), nexp);
    for (int i = 0; i < nexp && i < got.size(); i++) chk("out_word", got[i], src[i]);
    chk("sum", sum_out, SUM_ON ? exp_sum : 0);
    chk("done_pulses", done_cnt, 1);
    chk("idle_busy", busy, 0);
    exp_lat = SUM_ON ? 3 * nexp : 2 * nexp;
    if (stall) chk("lat_min", (lat >= exp_lat), 1);
    else chk("lat", lat, exp_lat);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_outputs_chk("rst");

    // Basic burst: 01..04, done 12 edges after the start edge (8 without sum).
    for (int i = 0; i < 16; i++) src[i] = 8'(i + 1);
    burst(4, 4, 32'h00A, 1'b0, 1'b0);

    // Full depth, all 0xFF.
    for (int i = 0; i < 16; i++) src[i] = 8'hFF;
    burst(8, 8, 32'h7F8, 1'b0, 1'b0);

    // len=12 clamps to 8; words beyond the eighth must never be taken.
    for (int i = 0; i < 16; i++) src[i] = (i < 8) ? 8'(i + 1) : 8'hEE;
    burst(12, 8, 36, 1'b0, 1'b0);

    // Random valid/ready stalls, len=5: 11+22+33+44+55 = FF.
    for (int i = 0; i < 16; i++) src[i] = 8'(8'h11 * (i + 1));
    burst(5, 5, 32'h0FF, 1'b1, 1'b0);

    // start with len=0 is ignored and sum_out holds.
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy", busy, 0);
    @(negedge clk);
    chk("len0_busy2", busy, 0);
    chk("len0_sum_hold", sum_out, SUM_ON ? 32'h0FF : 0);

    // start pulsed during DRAIN has no effect.
    for (int i = 0; i < 16; i++) src[i] = 8'(8'h40 + i);
    burst(4, 4, 32'h40 + 32'h41 + 32'h42 + 32'h43, 1'b0, 1'b1);
    @(negedge clk);
    chk("pulse_idle_busy", busy, 0);

    // Reset after 2 of 6 words loaded.
    @(negedge clk);
    start = 1'b1; len = 4'd6;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    in_data = 8'h66;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_outputs_chk("midrst");

    src[0] = 8'hA0; src[1] = 8'h0B;
    burst(2, 2, 32'h0AB, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
